// File: rtl/lsu_ram_pkg.sv
// Shared types for the load/store unit in front of a single-port word RAM.
// Optional range checking is enabled with the LSU_RAM_RANGE_CHECK_EN macro (see lsu_ram.sv).
package lsu_ram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Size 3 is never legal; halves need an even address, words a 4-byte aligned one.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lane[0];
      SZ_WORD: err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_ram_align.sv
// Byte/half lane extraction for loads and lane merge for read-modify-write stores.
// Purely combinational; the lane is the low two bits of the byte address.
module lsu_ram_align
  import lsu_ram_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_ram_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  always_comb begin
    byte_shift  = {i_lane, 3'b000};
    half_shift  = {i_lane[1], 4'b0000};
    byte_sel    = 8'(i_ram_word >> byte_shift);
    half_sel    = 16'(i_ram_word >> half_shift);
    byte_mask   = 32'h0000_00ff << byte_shift;
    half_mask   = 32'h0000_ffff << half_shift;
    o_load_data = i_ram_word;
    o_merged    = i_wdata;
    if (i_size == SZ_BYTE) begin
      o_load_data = i_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      o_merged    = (i_ram_word & ~byte_mask) |
                    ((32'(i_wdata[7:0]) << byte_shift) & byte_mask);
    end else if (i_size == SZ_HALF) begin
      o_load_data = i_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      o_merged    = (i_ram_word & ~half_mask) |
                    ((32'(i_wdata[15:0]) << half_shift) & half_mask);
    end
  end

endmodule

// File: rtl/lsu_ram.sv
// Load/store unit driving one port of a write-first RAM with 1-cycle read latency.
// Define LSU_RAM_RANGE_CHECK_EN to flag addresses beyond DEPTH words instead of wrapping.
module lsu_ram
  import lsu_ram_pkg::*;
#(
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both 1; valid, once raised, holds its payload until then.
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [1:0]               i_req_size,
  input  logic                     i_req_unsigned,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]    o_ram_data,
  output logic                     o_ram_we,
  input  logic [DATA_WIDTH-1:0]    i_ram_data
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   merged_q, merged_d;
  logic          err_q, err_d;

  logic          range_err;
  logic          req_err;
  logic          word_store;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;

`ifdef LSU_RAM_RANGE_CHECK_EN
  assign range_err = ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH));
`else
  // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH words.
  logic unused_addr_hi;
  assign range_err      = 1'b0;
  assign unused_addr_hi = ^i_req_addr[31:AW+2];
`endif

  assign req_err    = access_err(i_req_size, i_req_addr[1:0]) | range_err;
  assign word_store = we_q && (size_q == SZ_WORD);

  lsu_ram_align u_align (
    .i_size      (size_q),
    .i_uns       (uns_q),
    .i_lane      (addr_q[1:0]),
    .i_ram_word  (i_ram_data),
    .i_wdata     (wdata_q),
    .o_load_data (load_data),
    .o_merged    (merged_word)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          size_d  = i_req_size;
          uns_d   = i_req_unsigned;
          addr_d  = i_req_addr[AW+1:0];
          wdata_d = i_req_wdata;
          rdata_d = 32'h0;
          err_d   = req_err;
          state_d = req_err ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = word_store ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (we_q) begin
          merged_d = merged_word;
          state_d  = ST_WRITE;
        end else begin
          rdata_d  = load_data;
          state_d  = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (i_rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      merged_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
      err_q    <= err_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_rdata = o_rsp_valid ? rdata_q : 32'h0;
  assign o_rsp_err   = o_rsp_valid & err_q;
  assign o_ram_addr  = addr_q[AW+1:2];
  assign o_ram_we    = ((state_q == ST_ISSUE) && word_store) || (state_q == ST_WRITE);
  assign o_ram_data  = (state_q == ST_WRITE) ? merged_q : wdata_q;

endmodule

// File: tb/tb_lsu_ram.sv
// Bench for lsu_ram: byte-addressed reference memory model, directed cases, then random traffic.
module tb_lsu_ram;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = 4 * DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_uns;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          ram_we;

  logic [31:0] mem [DEPTH];
  logic [7:0]  ref_b [NB];
  logic [31:0] exp_q [$];
  int          wr_cnt;
  int          total = 0;
  int          bad = 0;

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  initial begin
    wr_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    forever begin
      @(posedge clk);
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt++;
      end
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end
  end

  lsu_ram #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_ram_addr     (ram_addr),
    .o_ram_data     (ram_wdata),
    .o_ram_we       (ram_we),
    .i_ram_data     (ram_rdata)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    bit e;
    e = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`ifdef LSU_RAM_RANGE_CHECK_EN
    if ((addr >> 2) >= 32'(DEPTH)) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr);
    int          base, n;
    logic [31:0] v;
    base = int'(addr % 32'(NB));
    n    = 1 << size;
    v    = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[base + i]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hffff_ffff << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int base;
    base = int'(addr % 32'(NB));
    for (int i = 0; i < (1 << size); i++) ref_b[base + i] = wdata[8 * i +: 8];
  endtask

  function automatic logic [31:0] model_word(input int widx);
    return {ref_b[4 * widx + 3], ref_b[4 * widx + 2], ref_b[4 * widx + 1], ref_b[4 * widx]};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    bit          e;
    int          lat, exp_wr, wr0, cyc;
    logic [31:0] exp_rd, got_exp, rd_first;
    e      = model_err(size, addr);
    exp_rd = (!e && !we) ? model_load(size, uns, addr) : 32'h0;
    lat    = e ? 1 : (we ? ((size == 2'd2) ? 2 : 4) : 3);
    exp_wr = (!e && we) ? 1 : 0;
    if (!e && we) model_store(size, addr, wdata);
    exp_q.push_back(exp_rd);

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 20);
    check("rsp_latency", 32'(cyc), 32'(lat));
    got_exp = exp_q.pop_front();
    if (!rsp_valid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check("rsp_rdata", rsp_rdata, got_exp);
    check("rsp_err", 32'(rsp_err), 32'(e));
    rd_first = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd_first);
      check("hold_err", 32'(rsp_err), 32'(e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ram_writes", 32'(wr_cnt - wr0), 32'(exp_wr));
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] saved;
    logic [31:0] a;
    int          wr0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < 4; j++) ref_b[4 * i + j] = mem[i][8 * j +: 8];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // word store/load round trip, then byte RMW and sub-word loads
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_565A, 0);
    check("rmw_ram_word", mem[4], 32'hDEAD_5AEF);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_8001, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h17, 32'h0, 0);

    // misaligned and illegal-size accesses
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFE_F00D, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h1111_1111, 0);

    // back-pressure on the response
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

    // out-of-range / wrapping address
    do_req(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'(4 * DEPTH) + 32'd1, 32'h0000_00A5, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);

    // reset while a byte store waits for its read data
    saved = model_word(8);
    wr0   = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrmw_req_ready", 32'(req_ready), 32'd1);
    check("midrmw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrmw_rsp_err", 32'(rsp_err), 32'd0);
    check("midrmw_rsp_rdata", rsp_rdata, 32'h0);
    check("midrmw_ram_we", 32'(ram_we), 32'd0);
    check("midrmw_ram_addr", 32'(ram_addr), 32'd0);
    check("midrmw_ram_word", mem[8], saved);
    check("midrmw_writes", 32'(wr_cnt - wr0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2 * NB - 1));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // final sweep of the whole RAM against the model
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== model_word(i)) check("final_ram_word", mem[i], model_word(i));
    end
    check("final_ram_word0", mem[0], model_word(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
